// File: rtl/tb_result_monitor.sv
// Result monitor on the CPU data bus: tohost pass/fail, console char port, cycle timeout.
// Latency: bus_ready one cycle after the first valid cycle; no backpressure, non-hit addresses never ack.
module tb_result_monitor #(
  parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
  parameter int unsigned TIMEOUT      = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_ready,
  output logic [31:0] bus_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  output logic        done,
  output logic        pass,
  output logic [31:0] error,
  output logic [31:0] cycles
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_FAIL = 2'd2;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        hit_tohost;
  logic        hit_console;
  logic        accept;
  logic        tohost_wr;
  logic        tohost_rd;
  logic        console_wr;
  logic        timeout_hit;
  logic [31:0] status_word;

  assign hit_tohost  = bus_valid && (bus_addr == TOHOST_ADDR);
  assign hit_console = bus_valid && (bus_addr == CONSOLE_ADDR);

  // A request still held while its ack is out must not be taken a second time.
  assign accept      = (hit_tohost || hit_console) && !bus_ready;
  assign tohost_wr   = accept && bus_we && hit_tohost;
  assign tohost_rd   = accept && !bus_we && hit_tohost;
  assign console_wr  = accept && bus_we && hit_console;
  assign timeout_hit = (state == ST_RUN) && (cycles == TIMEOUT_LAST);

  assign status_word = {29'b0, (error != 32'd0), pass, done};

  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      bus_ready  <= 1'b0;
      bus_rdata  <= 32'd0;
      char_valid <= 1'b0;
      char_data  <= 8'd0;
      error      <= 32'd0;
      cycles     <= 32'd0;
    end else begin
      bus_ready  <= accept;
      bus_rdata  <= tohost_rd ? status_word : 32'd0;
      char_valid <= console_wr;
      if (console_wr) begin
        char_data <= bus_wdata[7:0];
      end

      if (state == ST_RUN && cycles != 32'hFFFF_FFFF) begin
        cycles <= cycles + 32'd1;
      end

      // A decisive tohost write on the timeout edge takes priority; an even write does not.
      if (state == ST_RUN) begin
        if (tohost_wr && bus_wdata == 32'd1) begin
          state <= ST_PASS;
        end else if (tohost_wr && bus_wdata[0]) begin
          state <= ST_FAIL;
          error <= bus_wdata >> 1;
        end else if (timeout_hit) begin
          state <= ST_FAIL;
          error <= 32'hFFFF_FFFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_tb_result_monitor.sv
// Directed bench for tb_result_monitor: pass/fail codes, reads, console, timeout, reset.
module tb_tb_result_monitor;

  localparam logic [31:0] TOHOST  = 32'h0000_1000;
  localparam logic [31:0] CONSOLE = 32'h0000_1004;

  logic        clk;
  logic        rst_n;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;
  logic        char_valid;
  logic [7:0]  char_data;
  logic        done;
  logic        pass;
  logic [31:0] error;
  logic [31:0] cycles;

  int total;
  int bad;

  tb_result_monitor #(
    .TOHOST_ADDR (TOHOST),
    .CONSOLE_ADDR(CONSOLE),
    .TIMEOUT     (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus_valid (bus_valid),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ready (bus_ready),
    .bus_rdata (bus_rdata),
    .char_valid(char_valid),
    .char_data (char_data),
    .done      (done),
    .pass      (pass),
    .error     (error),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at posedge+1 with cycles == 0.
  task automatic do_reset();
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // lat = edges until bus_ready (0 = never acknowledged within 8 edges).
  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output int lat);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wdata;
    lat       = 0;
    rdata     = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus_ready) begin
        lat   = i;
        rdata = bus_rdata;
        break;
      end
    end
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    total++; if ({bus_ready, char_valid, done, pass} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {bus_ready, char_valid, done, pass}); end
    total++; if ({bus_rdata, error, cycles, char_data} !== 104'd0) begin bad++; $display("FAIL reset_words rdata=%h error=%h cycles=%h char=%h want all 0", bus_rdata, error, cycles, char_data); end
  endtask

  task automatic test_pass();
    logic [31:0] rd;
    int lat;
    do_reset();
    idle(9);
    bus_xfer(1'b1, TOHOST, 32'd1, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL pass_latency got=%0d want=1", lat); end
    total++; if ({done, pass} !== 2'b11) begin bad++; $display("FAIL pass_flags got=%b want=11", {done, pass}); end
    total++; if (error !== 32'd0) begin bad++; $display("FAIL pass_error got=%h want=0", error); end
    total++; if (cycles !== 32'd10) begin bad++; $display("FAIL pass_cycles got=%0d want=10", cycles); end
    idle(3);
    total++; if (bus_ready !== 1'b0) begin bad++; $display("FAIL pass_ready_drop got=%b want=0", bus_ready); end
    total++; if (cycles !== 32'd10) begin bad++; $display("FAIL pass_cycles_frozen got=%0d want=10", cycles); end
    bus_xfer(1'b1, CONSOLE, 32'h0000_005A, rd, lat);
    total++; if ({char_valid, char_data} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL pass_console got=%b/%h want=1/5a", char_valid, char_data); end
  endtask

  task automatic test_fail_code();
    logic [31:0] rd;
    int lat;
    do_reset();
    bus_xfer(1'b1, TOHOST, 32'h0000_000B, rd, lat);
    total++; if ({done, pass} !== 2'b10) begin bad++; $display("FAIL fail_flags got=%b want=10", {done, pass}); end
    total++; if (error !== 32'd5) begin bad++; $display("FAIL fail_error got=%h want=5", error); end
    idle(1);
    bus_xfer(1'b0, TOHOST, 32'd0, rd, lat);
    total++; if (lat !== 1 || rd !== 32'h5) begin bad++; $display("FAIL read_tohost got lat=%0d data=%h want 1/5", lat, rd); end
    idle(1);
    bus_xfer(1'b0, CONSOLE, 32'd0, rd, lat);
    total++; if (lat !== 1 || rd !== 32'h0) begin bad++; $display("FAIL read_console got lat=%0d data=%h want 1/0", lat, rd); end
    total++; if (error !== 32'd5 || char_valid !== 1'b0) begin bad++; $display("FAIL read_side_effect error=%h char_valid=%b want 5/0", error, char_valid); end
  endtask

  task automatic test_ignored();
    logic [31:0] rd;
    int lat;
    do_reset();
    bus_xfer(1'b1, TOHOST, 32'd2, rd, lat);
    total++; if (lat !== 1 || done !== 1'b0) begin bad++; $display("FAIL even_write got lat=%0d done=%b want 1/0", lat, done); end
    idle(1);
    bus_xfer(1'b1, 32'h0001_1000, 32'd1, rd, lat);
    total++; if (lat !== 0 || done !== 1'b0) begin bad++; $display("FAIL nonhit_write got lat=%0d done=%b want 0/0", lat, done); end
    bus_xfer(1'b0, 32'h0000_1008, 32'd0, rd, lat);
    total++; if (lat !== 0) begin bad++; $display("FAIL nonhit_read got lat=%0d want 0", lat); end
  endtask

  task automatic test_console();
    int nrdy;
    int nchr;
    logic [7:0] seen;
    do_reset();
    nrdy = 0;
    nchr = 0;
    seen = 8'h00;
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = CONSOLE;
    bus_wdata = 32'h1234_5641;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus_ready) nrdy++;
      if (char_valid) begin nchr++; seen = char_data; end
      if (i == 1) begin bus_valid = 1'b0; bus_we = 1'b0; bus_addr = 32'd0; bus_wdata = 32'd0; end
    end
    total++; if (nrdy !== 1) begin bad++; $display("FAIL console_ready_pulses got=%0d want=1", nrdy); end
    total++; if (nchr !== 1) begin bad++; $display("FAIL console_char_pulses got=%0d want=1", nchr); end
    total++; if (seen !== 8'h41) begin bad++; $display("FAIL console_char_data got=%h want=41", seen); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int lat;
    do_reset();
    idle(99);
    total++; if (done !== 1'b0 || cycles !== 32'd99) begin bad++; $display("FAIL timeout_early done=%b cycles=%0d want 0/99", done, cycles); end
    idle(1);
    total++; if ({done, pass} !== 2'b10) begin bad++; $display("FAIL timeout_flags got=%b want=10", {done, pass}); end
    total++; if (error !== 32'hFFFF_FFFF) begin bad++; $display("FAIL timeout_error got=%h want=ffffffff", error); end
    total++; if (cycles !== 32'd100) begin bad++; $display("FAIL timeout_cycles got=%0d want=100", cycles); end
    idle(5);
    bus_xfer(1'b1, TOHOST, 32'd1, rd, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL timeout_late_ack got=%0d want=1", lat); end
    total++; if (error !== 32'hFFFF_FFFF || pass !== 1'b0 || cycles !== 32'd100) begin bad++; $display("FAIL timeout_terminal error=%h pass=%b cycles=%0d want ffffffff/0/100", error, pass, cycles); end
  endtask

  task automatic test_race();
    logic [31:0] rd;
    int lat;
    do_reset();
    idle(99);
    bus_xfer(1'b1, TOHOST, 32'd1, rd, lat);
    total++; if (lat !== 1 || {done, pass} !== 2'b11) begin bad++; $display("FAIL race_flags lat=%0d done/pass=%b want 1/11", lat, {done, pass}); end
    total++; if (error !== 32'd0 || cycles !== 32'd100) begin bad++; $display("FAIL race_error error=%h cycles=%0d want 0/100", error, cycles); end
  endtask

  task automatic test_async_reset();
    logic [31:0] rd;
    int lat;
    do_reset();
    bus_xfer(1'b1, TOHOST, 32'h0000_000B, rd, lat);
    idle(1);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = CONSOLE;
    bus_wdata = 32'h0000_0043;
    @(posedge clk);
    #1;
    total++; if ({bus_ready, char_valid, error} !== {2'b11, 32'd5}) begin bad++; $display("FAIL arst_pre ready=%b char=%b error=%h want 1/1/5", bus_ready, char_valid, error); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({bus_ready, char_valid, done, pass} !== 4'b0000) begin bad++; $display("FAIL arst_flags got=%b want=0000", {bus_ready, char_valid, done, pass}); end
    total++; if ({error, cycles, char_data} !== 72'd0) begin bad++; $display("FAIL arst_words error=%h cycles=%h char=%h want 0", error, cycles, char_data); end
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);
    total++; if (done !== 1'b0 || cycles !== 32'd3) begin bad++; $display("FAIL arst_restart done=%b cycles=%0d want 0/3", done, cycles); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 32'd0;
    bus_wdata = 32'd0;
    test_reset();
    test_pass();
    test_fail_code();
    test_ignored();
    test_console();
    test_timeout();
    test_race();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
